// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: pipelined decode stage with hazard stall, branch resolve, squash and ID/EX register; FORWARDING_EN limits stalls to load-use
module id_stage_pipelined #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  input  logic [DATA_W-1:0]     pc_in,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  exe_wb_en,
  input  logic                  exe_mem_r_en,
  input  logic                  mem_wb_en,
  input  logic                  flush,
  output logic                  stall_if,
  output logic                  br_taken,
  output logic [DATA_W-1:0]     br_target,
  output logic                  ex_valid,
  output logic                  ex_mem_r_en,
  output logic                  ex_mem_w_en,
  output logic                  ex_wb_en,
  output logic [3:0]            ex_cmd,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] ex_src1,
  output logic [REG_ADDR_W-1:0] ex_src2,
  output logic [DATA_W-1:0]     ex_val1,
  output logic [DATA_W-1:0]     ex_val2,
  output logic [DATA_W-1:0]     ex_reg2
);
  typedef struct packed {
    logic                  valid;
    logic                  mem_r;
    logic                  mem_w;
    logic                  wb;
    logic [3:0]            cmd;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [DATA_W-1:0]     reg2;
  } ex_t;
  logic [5:0]            op;
  logic [REG_ADDR_W-1:0] dest;
  logic [DATA_W-1:0]     sext_imm;
  logic [3:0]            cmd;
  logic reg_op, wb, mem_r, mem_w, imm_sel, use1, use2, sel_dest, is_bez, is_bne, is_jmp;
  logic squash, live, hit1, hit2, hazard, cond;
  ex_t  ex;
  assign op       = instr[31:26];
  assign dest     = instr[21 +: REG_ADDR_W];
  assign sext_imm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
  assign reg_op   = op inside {6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};
  // opcode decode; unlisted opcodes fall through as NOP
  always_comb begin
    cmd      = 4'b0000;
    wb       = reg_op;
    use2     = reg_op;
    mem_r    = 1'b0;
    mem_w    = 1'b0;
    imm_sel  = 1'b0;
    sel_dest = 1'b0;
    is_bez   = 1'b0;
    is_bne   = 1'b0;
    is_jmp   = 1'b0;
    case (op)
      6'd3:         cmd = 4'b0010;
      6'd5:         cmd = 4'b0100;
      6'd6:         cmd = 4'b0101;
      6'd7:         cmd = 4'b0110;
      6'd8:         cmd = 4'b0111;
      6'd9, 6'd10:  cmd = 4'b1000;
      6'd11:        cmd = 4'b1001;
      6'd12:        cmd = 4'b1010;
      6'd32:        begin imm_sel = 1'b1; wb = 1'b1; end
      6'd33:        begin cmd = 4'b0010; imm_sel = 1'b1; wb = 1'b1; end
      6'd36:        begin imm_sel = 1'b1; wb = 1'b1; mem_r = 1'b1; end
      6'd37:        begin imm_sel = 1'b1; mem_w = 1'b1; use2 = 1'b1; sel_dest = 1'b1; end
      6'd40:        is_bez = 1'b1;
      6'd41:        begin is_bne = 1'b1; use2 = 1'b1; sel_dest = 1'b1; end
      6'd42:        is_jmp = 1'b1;
      default:      ;
    endcase
    use1 = reg_op | imm_sel | is_bez | is_bne;
  end
  assign rf_raddr1 = instr[16 +: REG_ADDR_W];
  assign rf_raddr2 = sel_dest ? dest : instr[11 +: REG_ADDR_W];
  assign live      = instr_valid & ~squash;
`ifdef FORWARDING_EN
  assign hit1 = (|rf_raddr1) & (rf_raddr1 == exe_dest) & exe_mem_r_en;
  assign hit2 = (|rf_raddr2) & (rf_raddr2 == exe_dest) & exe_mem_r_en;
`else
  assign hit1 = (|rf_raddr1) & (((rf_raddr1 == exe_dest) & exe_wb_en) | ((rf_raddr1 == mem_dest) & mem_wb_en));
  assign hit2 = (|rf_raddr2) & (((rf_raddr2 == exe_dest) & exe_wb_en) | ((rf_raddr2 == mem_dest) & mem_wb_en));
`endif
  assign hazard    = live & ((use1 & hit1) | (use2 & hit2));
  assign stall_if  = hazard & ~flush;
  assign cond      = is_jmp | (is_bez & (rf_rdata1 == '0)) | (is_bne & (rf_rdata1 != rf_rdata2));
  assign br_taken  = live & cond & ~hazard & ~flush;
  assign br_target = pc_in + sext_imm;
  // one-slot branch-shadow kill; held across a stall so the killed slot is the next accepted one
  always_ff @(posedge clk or negedge rst)
    if (!rst) squash <= 1'b0;
    else squash <= flush ? 1'b0 : hazard ? squash : br_taken;
  // ID/EX register: bubble on flush or hazard, otherwise capture the decoded instruction
  always_ff @(posedge clk or negedge rst)
    if (!rst) ex <= '0;
    else if (flush | hazard) ex <= '0;
    else ex <= '{valid: live, mem_r: live & mem_r, mem_w: live & mem_w, wb: live & wb, cmd: cmd,
                 dest: dest, src1: rf_raddr1, src2: rf_raddr2, val1: rf_rdata1,
                 val2: imm_sel ? sext_imm : rf_rdata2, reg2: rf_rdata2};
  assign ex_valid    = ex.valid;
  assign ex_mem_r_en = ex.mem_r;
  assign ex_mem_w_en = ex.mem_w;
  assign ex_wb_en    = ex.wb;
  assign ex_cmd      = ex.cmd;
  assign ex_dest     = ex.dest;
  assign ex_src1     = ex.src1;
  assign ex_src2     = ex.src2;
  assign ex_val1     = ex.val1;
  assign ex_val2     = ex.val2;
  assign ex_reg2     = ex.reg2;
endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb_id_stage_pipelined: directed vectors checked against a behavioural decode model every cycle
module tb_id_stage_pipelined;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] instr = '0;
  logic instr_valid = 1'b0, exe_wb_en = 1'b0, exe_mem_r_en = 1'b0, mem_wb_en = 1'b0, flush = 1'b0;
  logic [DW-1:0] pc_in = '0, rf_rdata1 = '0, rf_rdata2 = '0;
  logic [RW-1:0] exe_dest = '0, mem_dest = '0;
  logic [RW-1:0] rf_raddr1, rf_raddr2, ex_dest, ex_src1, ex_src2;
  logic stall_if, br_taken, ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en;
  logic [3:0] ex_cmd;
  logic [DW-1:0] br_target, ex_val1, ex_val2, ex_reg2;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  id_stage_pipelined #(.DATA_W(DW), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .pc_in(pc_in),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_wb_en(mem_wb_en), .flush(flush), .stall_if(stall_if), .br_taken(br_taken),
    .br_target(br_target), .ex_valid(ex_valid), .ex_mem_r_en(ex_mem_r_en), .ex_mem_w_en(ex_mem_w_en),
    .ex_wb_en(ex_wb_en), .ex_cmd(ex_cmd), .ex_dest(ex_dest), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_val1(ex_val1), .ex_val2(ex_val2), .ex_reg2(ex_reg2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // instruction classes: 0 nop, 1 reg, 2 alu-imm, 3 load, 4 store, 5 bez, 6 bne, 7 jmp
  function automatic int kind_of(input logic [5:0] op);
    case (op)
      1, 3, 5, 6, 7, 8, 9, 10, 11, 12: return 1;
      32, 33: return 2;
      36: return 3;
      37: return 4;
      40: return 5;
      41: return 6;
      42: return 7;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] cmd_of(input logic [5:0] op);
    case (op)
      3, 33: return 4'd2;
      5: return 4'd4;
      6: return 4'd5;
      7: return 4'd6;
      8: return 4'd7;
      9, 10: return 4'd8;
      11: return 4'd9;
      12: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] enc_r(input int op, input int d, input int s1, input int s2);
    return {op[5:0], d[4:0], s1[4:0], s2[4:0], 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int d, input int s1, input logic [15:0] imm);
    return {op[5:0], d[4:0], s1[4:0], imm};
  endfunction

  int m_k;
  logic [RW-1:0] m_ra1, m_ra2;
  logic m_v, h1, h2, m_haz, m_stall, m_br, m_sq = 1'b0;
  logic signed [DW-1:0] m_imm;
  logic [DW-1:0] m_tgt;
  always_comb begin
    m_k   = kind_of(instr[31:26]);
    m_ra1 = instr[20:16];
    m_ra2 = (m_k == 4 || m_k == 6) ? instr[25:21] : instr[15:11];
    m_v   = instr_valid && !m_sq;
    h1 = FWD ? (m_ra1 != 0 && m_ra1 == exe_dest && exe_mem_r_en)
             : (m_ra1 != 0 && ((m_ra1 == exe_dest && exe_wb_en) || (m_ra1 == mem_dest && mem_wb_en)));
    h2 = FWD ? (m_ra2 != 0 && m_ra2 == exe_dest && exe_mem_r_en)
             : (m_ra2 != 0 && ((m_ra2 == exe_dest && exe_wb_en) || (m_ra2 == mem_dest && mem_wb_en)));
    m_haz   = m_v && ((m_k != 0 && m_k != 7 && h1) || ((m_k == 1 || m_k == 4 || m_k == 6) && h2));
    m_stall = m_haz && !flush;
    m_imm   = DW'($signed(instr[15:0]));
    m_tgt   = pc_in + m_imm;
    m_br    = m_v && !m_haz && !flush &&
              (m_k == 7 || (m_k == 5 && rf_rdata1 == 0) || (m_k == 6 && rf_rdata1 != rf_rdata2));
  end

  logic e_valid = 0, e_wb = 0, e_mr = 0, e_mw = 0;
  logic [3:0] e_cmd = 0;
  logic [RW-1:0] e_dest = 0, e_s1 = 0, e_s2 = 0;
  logic [DW-1:0] e_v1 = 0, e_v2 = 0, e_r2 = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      {e_valid, e_wb, e_mr, e_mw, e_cmd, e_dest, e_s1, e_s2, e_v1, e_v2, e_r2} <= '0;
      m_sq <= 1'b0;
    end else if (flush || m_haz) begin
      {e_valid, e_wb, e_mr, e_mw} <= '0;
      if (flush) m_sq <= 1'b0;
    end else begin
      e_valid <= m_v;
      e_wb    <= m_v && (m_k inside {1, 2, 3});
      e_mr    <= m_v && m_k == 3;
      e_mw    <= m_v && m_k == 4;
      e_cmd   <= cmd_of(instr[31:26]);
      e_dest  <= instr[25:21];
      e_s1    <= m_ra1;
      e_s2    <= m_ra2;
      e_v1    <= rf_rdata1;
      e_v2    <= (m_k inside {2, 3, 4}) ? m_imm : rf_rdata2;
      e_r2    <= rf_rdata2;
      m_sq    <= m_br;
    end
  end

  always @(negedge clk) begin
    chk("rf_raddr1", rf_raddr1, m_ra1);
    chk("rf_raddr2", rf_raddr2, m_ra2);
    chk("stall_if", stall_if, m_stall);
    chk("br_taken", br_taken, m_br);
    if (m_br) chk("br_target", br_target, m_tgt);
    chk("ex_valid", ex_valid, e_valid);
    chk("ex_wb_en", ex_wb_en, e_wb);
    chk("ex_mem_r_en", ex_mem_r_en, e_mr);
    chk("ex_mem_w_en", ex_mem_w_en, e_mw);
    if (e_valid || !rst) begin
      chk("ex_cmd", ex_cmd, e_cmd);
      chk("ex_dest", ex_dest, e_dest);
      chk("ex_src1", ex_src1, e_s1);
      chk("ex_src2", ex_src2, e_s2);
      chk("ex_val1", ex_val1, e_v1);
      chk("ex_val2", ex_val2, e_v2);
      chk("ex_reg2", ex_reg2, e_r2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    instr = i;
    instr_valid = 1'b1;
    rf_rdata1 = a;
    rf_rdata2 = b;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b1; tick();
    chk("idle ex_valid", ex_valid, 0);
    put(enc_r(1, 3, 1, 2), 5, 7); #1;
    chk("add raddr1", rf_raddr1, 1);
    chk("add raddr2", rf_raddr2, 2);
    tick();
    chk("add ex_valid", ex_valid, 1);
    tick();
    rst = 1'b0; #1;
    chk("async rst ex_valid", ex_valid, 0);
    chk("async rst ex_wb_en", ex_wb_en, 0);
    chk("async rst ex_val1", ex_val1, 0);
    chk("async rst ex_dest", ex_dest, 0);
    tick();
    rst = 1'b1; tick();
    chk("add2 ex_valid", ex_valid, 1);
    chk("add2 ex_cmd", ex_cmd, 4'b0000);
    chk("add2 ex_dest", ex_dest, 3);
    chk("add2 ex_val1", ex_val1, 5);
    chk("add2 ex_val2", ex_val2, 7);
    chk("add2 ex_wb_en", ex_wb_en, 1);
    put(enc_i(32, 4, 1, 16'hFFFE), 5, 0); tick();
    chk("addi ex_val2", ex_val2, 32'hFFFFFFFE);
    chk("addi ex_wb_en", ex_wb_en, 1);
    put(enc_i(37, 6, 1, 16'd8), 9, 33); #1;
    chk("st raddr2", rf_raddr2, 6);
    tick();
    chk("st ex_mem_w_en", ex_mem_w_en, 1);
    chk("st ex_wb_en", ex_wb_en, 0);
    chk("st ex_val2", ex_val2, 8);
    chk("st ex_reg2", ex_reg2, 33);
    put(enc_r(1, 2, 1, 0), 1, 0);
    exe_dest = 1; exe_wb_en = 1; #1;
    chk("raw exe stall_if", stall_if, !FWD);
    tick();
    chk("raw exe ex_valid", ex_valid, FWD);
    exe_dest = 0; exe_wb_en = 0; #1;
    chk("raw clear stall_if", stall_if, 0);
    tick();
    chk("raw issue ex_valid", ex_valid, 1);
    chk("raw issue ex_dest", ex_dest, 2);
    mem_dest = 1; mem_wb_en = 1; #1;
    chk("raw mem stall_if", stall_if, !FWD);
    tick();
    chk("raw mem ex_valid", ex_valid, FWD);
    mem_dest = 0; mem_wb_en = 0;
    exe_dest = 1; exe_wb_en = 1; exe_mem_r_en = 1; #1;
    chk("load-use stall_if", stall_if, 1);
    tick();
    chk("load-use ex_valid", ex_valid, 0);
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; tick();
    chk("load-use issue", ex_valid, 1);
    put(enc_i(41, 2, 1, 16'd5), 3, 4); pc_in = 100; #1;
    chk("bne br_taken", br_taken, 1);
    chk("bne br_target", br_target, 105);
    chk("bne raddr2", rf_raddr2, 2);
    tick();
    chk("bne ex_valid", ex_valid, 1);
    chk("bne ex_wb_en", ex_wb_en, 0);
    put(enc_r(1, 7, 1, 2), 1, 1); tick();
    chk("shadow ex_valid", ex_valid, 0);
    chk("shadow ex_wb_en", ex_wb_en, 0);
    put(enc_r(1, 8, 1, 2), 1, 1); tick();
    chk("after shadow ex_valid", ex_valid, 1);
    chk("after shadow ex_dest", ex_dest, 8);
    put(enc_i(40, 0, 1, 16'h0010), 1, 0); pc_in = 20; #1;
    chk("bez nt br_taken", br_taken, 0);
    tick();
    put(enc_r(1, 9, 1, 2), 1, 1); tick();
    chk("bez nt next ex_valid", ex_valid, 1);
    put(enc_i(40, 0, 1, 16'hFFFC), 0, 0); pc_in = 200; #1;
    chk("bez t br_taken", br_taken, 1);
    chk("bez t br_target", br_target, 196);
    tick();
    put(enc_i(42, 0, 0, 16'd3), 0, 0); pc_in = 50; #1;
    chk("jmp in shadow br_taken", br_taken, 0);
    tick();
    chk("jmp in shadow ex_valid", ex_valid, 0);
    chk("jmp br_taken", br_taken, 1);
    chk("jmp br_target", br_target, 53);
    tick();
    chk("jmp ex_valid", ex_valid, 1);
    put(enc_r(1, 12, 1, 2), 0, 0); flush = 1; tick();
    chk("flush in shadow ex_valid", ex_valid, 0);
    flush = 0; put(enc_r(1, 13, 1, 2), 0, 0); tick();
    chk("post flush ex_valid", ex_valid, 1);
    put(enc_i(41, 4, 1, 16'd7), 3, 4);
    exe_dest = 1; exe_wb_en = 1; flush = 1; #1;
    chk("flush br_taken", br_taken, 0);
    chk("flush stall_if", stall_if, 0);
    tick();
    chk("flush ex_valid", ex_valid, 0);
    flush = 0; exe_dest = 0; exe_wb_en = 0;
    put(enc_r(1, 10, 1, 2), 0, 0); tick();
    chk("after flush ex_valid", ex_valid, 1);
    put(enc_r(1, 5, 0, 0), 0, 0); exe_dest = 0; exe_wb_en = 1; #1;
    chk("r0 stall_if", stall_if, 0);
    tick();
    chk("r0 ex_valid", ex_valid, 1);
    chk("r0 ex_dest", ex_dest, 5);
    exe_wb_en = 0;
    put(enc_r(2, 11, 1, 2), 1, 1); tick();
    chk("bad op ex_wb_en", ex_wb_en, 0);
    put(enc_i(36, 14, 3, 16'h0004), 8, 0); tick();
    chk("ld ex_mem_r_en", ex_mem_r_en, 1);
    chk("ld ex_val2", ex_val2, 4);
    put(enc_r(11, 15, 3, 4), 8, 2); tick();
    chk("sra ex_cmd", ex_cmd, 4'b1001);
    instr_valid = 0; tick(); tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
- Parametrised successor to the combinational decode stage: decodes one instruction per cycle, drives register-file read addresses, resolves branches, detects RAW hazards and owns the ID/EX pipeline register.
- Adds stall, flush, branch-shadow squash and a valid bit.
- Sits between the IF/ID register and the EXE stage.

Parameters:
- DATA_W, 32, datapath width; immediates sign-extend to DATA_W.
- REG_ADDR_W, 5, register address width; instruction fields use the low REG_ADDR_W bits of each 5-bit field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr  in  32  instruction word: op[31:26], dest[25:21], src1[20:16], src2[15:11], imm[15:0].
- instr_valid  in  1  instr is live.
- pc_in  in  DATA_W  PC+1 of instr.
- rf_raddr1, rf_raddr2  out  REG_ADDR_W  read addresses to the register file (combinational).
- rf_rdata1, rf_rdata2  in  DATA_W  register-file read data, same cycle.
- exe_dest, mem_dest  in  REG_ADDR_W  destinations of the instructions in EXE and MEM.
- exe_wb_en, exe_mem_r_en, mem_wb_en  in  1  control bits of those instructions.
- flush  in  1  external kill (exception).
- stall_if  out  1  hold PC and IF/ID (combinational).
- br_taken  out  1  redirect IF (combinational).
- br_target  out  DATA_W  pc_in + sext(imm).
- ex_valid, ex_mem_r_en, ex_mem_w_en, ex_wb_en  out  1  registered.
- ex_cmd  out  4  registered ALU command.
- ex_dest, ex_src1, ex_src2  out  REG_ADDR_W  registered.
- ex_val1, ex_val2, ex_reg2  out  DATA_W  registered.

Behaviour:
- Reset (rst=0, asynchronous): all ex_* outputs are 0 and the squash flag is cleared. Combinational outputs follow their inputs.
- Addressing:
  - rf_raddr1 = src1.
  - rf_raddr2 = dest for ST/BNE, else src2.
  - val1 = rdata1.
  - val2 = sext(imm) for immediate-type instructions, else rdata2.
  - reg2 = rdata2.
- Opcode map (op: cmd, flags):
  - 0 NOP: wb=0.
  - Register ops, wb=1: 1 ADD 0000; 3 SUB 0010; 5 AND 0100; 6 OR 0101; 7 NOR 0110; 8 XOR 0111; 9/10 SLA/SLL 1000; 11 SRA 1001; 12 SRL 1010.
  - Immediate ops: 32 ADDI 0000 imm wb; 33 SUBI 0010 imm wb; 36 LD 0000 imm mem_r wb; 37 ST 0000 imm mem_w.
  - Branches: 40 BEZ (taken if rdata1==0); 41 BNE (taken if rdata1!=rdata2); 42 JMP (always taken).
  - Any other opcode decodes as NOP.
- Hazard detection:
  - An instruction uses src1 for every opcode except NOP and JMP.
  - It uses raddr2 for register ops, ST and BNE.
  - hazard = instr_valid & uses & (rf_raddr == exe_dest & exe_wb_en, or rf_raddr == mem_dest & mem_wb_en); register 0 never hazards.
  - stall_if = hazard & ~flush.
- br_taken = instr_valid & branch-condition & ~hazard & ~squash & ~flush.
- Squash: one-bit flag, set on the edge after br_taken=1 and cleared after one accepted cycle. While set, the current instr is treated as invalid (branch-delay kill, exactly one slot).
- ID/EX register update each rising edge:
  - flush=1: bubble (ex_valid=0, all enables 0). Flush has priority over stall and clears the squash flag.
  - hazard: bubble. IF is held, so instr re-presents next cycle.
  - otherwise: load the decoded fields; ex_valid = instr_valid & ~squash.
- A bubble always forces ex_wb_en = ex_mem_r_en = ex_mem_w_en = 0. Branches and JMP load with wb=0.
- Reset deasserting mid-stream gives ex_valid=0 until the first accepted instruction.

Optional Feature:
- FORWARDING_EN, when defined: hazard checks only load-use, i.e. match against exe_dest & exe_mem_r_en; the mem_dest comparison is removed. A downstream forwarding unit covers all other RAW cases. ex_src1/ex_src2 carry the operand addresses it needs.
- When undefined: full RAW stall as specified above. ex_src1/ex_src2 are still driven.

Test Plan:
- Reset: rst=0 mid-stream with ADD in flight → all ex_* are 0 immediately (no clock). Release, then ADD r3,r1,r2 with rdata=5,7 → next edge ex_valid=1, ex_cmd=0000, ex_dest=3, ex_val1=5, ex_val2=7, ex_wb_en=1.
- Immediate / store: ADDI r4,r1,-2 (imm=0xFFFE) → ex_val2=0xFFFFFFFE. ST r6,r1,8 → rf_raddr2=6, ex_mem_w_en=1, ex_wb_en=0, ex_val2=8.
- RAW stall:
  - FORWARDING_EN off: ADD r2,r1,r0 with exe_dest=1, exe_wb_en=1 → stall_if=1 and a bubble. When exe_dest clears → issues.
  - FORWARDING_EN on: the same case → no stall. LD pending in EXE (exe_dest=1, exe_mem_r_en=1) → stall.
- Branch: BNE with rdata1=3, rdata2=4, pc_in=100, imm=5 → br_taken=1, br_target=105. The following instruction is squashed (ex_valid=0). The instruction after that issues. BEZ with rdata1=1 → br_taken=0.
- Simultaneous events: flush=1 together with a hazard and a taken branch → br_taken=0, stall_if=0, bubble loaded, squash flag cleared.
- Register 0: ADD r5,r0,r0 with exe_dest=0, exe_wb_en=1 → no stall.
